// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: E-stage multiply/divide sequencer that owns HI/LO and raises busy/stall_d.
// Optional MDU_CANCEL_EN: flush aborts an in-flight op and suppresses a same-cycle start.
module mdu_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_uses_mdu,
    input  logic        flush,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_ok;

    logic        is_mul, is_div, is_long, is_mthi, is_mtlo;
    logic        kill, accept, launch, commit;

    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_long = is_mul || is_div;
    assign is_mthi = (op == OP_MTHI);
    assign is_mtlo = (op == OP_MTLO);

`ifdef MDU_CANCEL_EN
    assign kill = flush;
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign kill = 1'b0;
`endif

    assign accept = start && (state == IDLE) && !kill;
    assign launch = accept && is_long;

    // ---------------- arithmetic (result captured on the launch edge)
    logic [63:0] a_sx, b_sx, prod_s, prod_u, result;
    logic        a_neg, b_neg, result_ok;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, qs, rs, qu, ru;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide through magnitudes: truncates toward zero, remainder follows the
    // dividend, and 0x80000000 / -1 wraps back to 0x80000000 without special casing.
    assign a_neg = a[31];
    assign b_neg = b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign qs    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rs    = a_neg ? (~r_mag + 32'd1) : r_mag;
    assign qu    = (b == 32'd0) ? 32'd0 : (a / b);
    assign ru    = (b == 32'd0) ? 32'd0 : (a % b);

    always_comb begin
        result = 64'd0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rs, qs};
            OP_DIVU:  result = {ru, qu};
            default:  result = 64'd0;
        endcase
    end

    // Divide by zero still occupies the unit but leaves HI/LO untouched.
    assign result_ok = !(is_div && (b == 32'd0));

    // ---------------- FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (kill || (cnt == 4'd1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs
    always_comb begin
        busy   = (state == RUN);
        commit = (state == RUN) && (cnt == 4'd1) && !kill && pend_ok;
    end

    // ---------------- counter and pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_ok <= 1'b0;
        end else if (launch) begin
            cnt     <= is_mul ? MULT_LD : DIV_LD;
            pend    <= result;
            pend_ok <= result_ok;
        end else if (state == RUN) begin
            if (kill) begin
                cnt     <= 4'd0;
                pend    <= 64'd0;
                pend_ok <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // ---------------- HI/LO architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= pend[63:32];
            lo <= pend[31:0];
        end else if (accept && is_mthi) begin
            hi <= a;
        end else if (accept && is_mtlo) begin
            lo <= a;
        end
    end

    // ---------------- E-stage read port and hazard request
    always_comb begin
        out = 32'd0;
        case (op)
            OP_MFHI: out = hi;
            OP_MFLO: out = lo;
            default: out = 32'd0;
        endcase
    end

    // The start term covers the issue cycle, before busy has risen.
    assign stall_d = d_uses_mdu && (busy || (start && is_long));

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && start && (state == RUN) && (op >= OP_MULT) && (op <= OP_MFLO))
            $error("mdu_seq_ctrl: start op %0d while busy is ignored", op);
    end
`endif

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Sequencing controller for the E-stage multiply/divide resource of the 5-stage MIPS pipeline.
- Accepts one MDU operation per start pulse and runs a fixed-latency multi-cycle schedule.
- Owns the HI/LO architectural registers and serves mfhi/mflo reads.
- Generates `busy` and a D-stage stall request for the hazard unit, so MDU-dependent instructions wait while an operation is in flight.

Parameters:
- MULT_CYCLES, 5: busy duration for mult/multu, in cycles; legal range 1..15.
- DIV_CYCLES, 10: busy duration for div/divu, in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  E-stage pulse; operation in `op` is valid this cycle.
- op  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9..15 treated as none.
- a  in  32  operand A (rs, already forwarded).
- b  in  32  operand B (rt, already forwarded).
- d_uses_mdu  in  1  D-stage instruction is an MDU op (any of codes 1..8).
- flush  in  1  cancel request; used only when MDU_CANCEL_EN is defined.
- busy  out  1  multi-cycle operation in flight.
- stall_d  out  1  D-stage stall request to the hazard unit.
- out  in E stage: out  32  E-stage result: HI when op=7, LO when op=8, else 0.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

Behaviour:
- Reset values: busy=0, stall_d=0, out=0, hi=0, lo=0; state=IDLE, counter=0, pending result=0.
- Reset is asynchronous: asserting it mid-operation aborts the operation at once; HI/LO become 0.
- States: IDLE and RUN.
- IDLE, start with op in 1..4:
  - Capture the full 64-bit result into the pending register on the same edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises on the cycle after the start cycle.
- RUN:
  - Counter decrements every edge.
  - On the edge where counter==1: commit pending {hi,lo}, return to IDLE.
  - busy is high for exactly N cycles; the new HI/LO are visible in the first cycle with busy=0.
- Arithmetic:
  - mult/multu: {hi,lo} = 64-bit signed / unsigned product.
  - div/divu: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b==0): operation still runs DIV_CYCLES; HI/LO are left unchanged at commit.
- mthi/mtlo with start in IDLE: hi (or lo) = a on that edge; single cycle, busy stays 0.
- mfhi/mflo: `out` is combinational from the current hi/lo in the same cycle; no state change.
- stall_d = d_uses_mdu & (busy | (start & op in 1..4)). This covers the issue cycle, before busy has risen.
- start while RUN:
  - Ignored, no state change (the hazard unit guarantees this does not happen).
  - The simulation-only check prints an error.
- start with op=0 or op in 9..15: no effect.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - flush high in RUN aborts the operation: back to IDLE on that edge, pending result discarded, HI/LO unchanged, busy=0 next cycle.
  - flush high together with start in IDLE suppresses the start, including mthi/mtlo writes.
- Undefined: the flush port is ignored; every started operation completes and commits.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3 -> busy high cycles 1..5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu, a=100, b=7 -> busy for 10 cycles; then lo=14, hi=2. div, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi a=0x12345678, then mfhi next cycle -> out=0x12345678, busy never asserted. div with b=0 after that -> hi still 0x12345678 after 10 busy cycles.
- Start mult 6*7; hold d_uses_mdu=1 -> stall_d=1 in the start cycle and for all 5 busy cycles, 0 afterwards; lo=42.
- Assert reset asynchronously at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately, with no commit on later edges.
- With MDU_CANCEL_EN: flush at busy cycle 2 of mult 5*5 -> busy=0 next cycle, lo keeps its prior value. Without the macro -> lo=25 after 5 cycles.
